e_mdu: RTL

- Parametrised multi-cycle multiply/divide unit in the E stage, beside the ALU.
- Holds architectural HI/LO registers and supports mult, multu, div, divu, mthi and mtlo.
- Emulates the fixed multi-cycle latency of the target core through a busy window.
- The hazard unit stalls D-stage MDU instructions while busy or start is high.

---
 rtl/e_mdu_if.sv | 30 +++
 rtl/e_mdu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu_if.sv
// ============================================================================
// Module   : e_mdu_if
// Brief    : E-stage multiply/divide unit request and HI/LO result bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDUOp, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDUOp, A, B,
        output busy, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// Module   : e_mdu
// Brief    : Multi-cycle mult/div unit with architectural HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset_n,
    e_mdu_if.slave mdu
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LD  = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LD   = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_ZERO     = '0;

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_ph;
    logic [WIDTH-1:0]   r_pl;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_launch;
    logic               w_commit;
    logic               w_idle;
    logic               w_op_valid;
    logic               w_is_div;
    logic               w_is_signed;

    logic [2*WIDTH-1:0] w_ma;
    logic [2*WIDTH-1:0] w_mb;
    logic [2*WIDTH-1:0] w_prod;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_b_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_ph;
    logic [WIDTH-1:0]   w_pl;

    assign w_op_valid  = (mdu.MDUOp == c_OP_MULT) || (mdu.MDUOp == c_OP_MULTU) ||
                         (mdu.MDUOp == c_OP_DIV)  || (mdu.MDUOp == c_OP_DIVU);
    assign w_is_div    = (mdu.MDUOp == c_OP_DIV)  || (mdu.MDUOp == c_OP_DIVU);
    assign w_is_signed = (mdu.MDUOp == c_OP_MULT) || (mdu.MDUOp == c_OP_DIV);

    // Sign/zero extension to 2*WIDTH lets one unsigned multiplier produce both products.
    assign w_ma   = w_is_signed ? {{WIDTH{mdu.A[WIDTH-1]}}, mdu.A} : {c_ZERO, mdu.A};
    assign w_mb   = w_is_signed ? {{WIDTH{mdu.B[WIDTH-1]}}, mdu.B} : {c_ZERO, mdu.B};
    assign w_prod = w_ma * w_mb;

    // Signed divide runs on magnitudes; the most-negative / -1 case falls out naturally.
    assign w_a_neg  = w_is_signed && mdu.A[WIDTH-1];
    assign w_b_neg  = w_is_signed && mdu.B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~mdu.A + c_ONE) : mdu.A;
    assign w_b_mag  = w_b_neg ? (~mdu.B + c_ONE) : mdu.B;
    assign w_b_safe = (w_b_mag == c_ZERO) ? c_ONE : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + c_ONE) : w_q_mag;
    assign w_r      = w_a_neg ? (~w_r_mag + c_ONE) : w_r_mag;

    assign w_ph = w_is_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
    assign w_pl = w_is_div ? w_q : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_idle      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idle = 1'b1;
                if (mdu.start && w_op_valid) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_ph  <= '0;
            r_pl  <= '0;
            r_dz  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_launch) begin
                r_ph  <= w_ph;
                r_pl  <= w_pl;
                r_dz  <= w_is_div && (mdu.B == c_ZERO);
                r_cnt <= w_is_div ? c_DIV_LD : c_MULT_LD;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end

            if (w_commit && !r_dz) begin
                r_hi <= r_ph;
            end else if (w_idle && (mdu.MDUOp == c_OP_MTHI)) begin
                r_hi <= mdu.A;
            end

            if (w_commit && !r_dz) begin
                r_lo <= r_pl;
            end else if (w_idle && (mdu.MDUOp == c_OP_MTLO)) begin
                r_lo <= mdu.A;
            end
        end
    end

    assign mdu.busy = (r_state == S_RUN);
    assign mdu.HI   = r_hi;
    assign mdu.LO   = r_lo;

endmodule

`default_nettype wire
